// File: rtl/uart_rx_ctrl.sv
// 8N1 UART receiver with 16x oversampling and a 4-entry receive FIFO.
// Byte visible on rx_valid one cycle after the stop-bit sample; rx_ready pops the head, a full FIFO drops the byte.
module uart_rx_ctrl #(
    parameter int OVS_DIV    = 27,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk_50,
    input  logic       rst_n,
    input  logic       uart_rx,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic [2:0] fifo_count
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [11:0] TICK_MAX  = 12'(OVS_DIV - 1);
    localparam logic [2:0]  FIFO_FULL = 3'(FIFO_DEPTH);

    logic        rx_meta;
    logic        rxs;
    logic [11:0] tick_cnt;
    logic        tick;

    state_t      state, state_nxt;
    logic [3:0]  sample_cnt, sample_cnt_nxt;
    logic [2:0]  bit_idx, bit_idx_nxt;
    logic [7:0]  shift_reg, shift_nxt;
    logic        push;
    logic        stop_bad;

    logic [7:0]  mem [4];
    logic [1:0]  wr_ptr, rd_ptr;
    logic        full, pop, push_ok, drop;

    // Line idles high, so the synchronizer resets high to avoid a false start bit.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 12'd1;
        end
    end

    assign tick = (tick_cnt == TICK_MAX);

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sample_cnt <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
        end else begin
            state      <= state_nxt;
            sample_cnt <= sample_cnt_nxt;
            bit_idx    <= bit_idx_nxt;
            shift_reg  <= shift_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        sample_cnt_nxt = sample_cnt;
        bit_idx_nxt    = bit_idx;
        shift_nxt      = shift_reg;
        push           = 1'b0;
        stop_bad       = 1'b0;
        if (tick) begin
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state_nxt      = START;
                        sample_cnt_nxt = '0;
                    end
                end
                START: begin
                    // Mid start bit: still low means a real frame, high means a glitch.
                    if (sample_cnt == 4'd7) begin
                        sample_cnt_nxt = '0;
                        bit_idx_nxt    = '0;
                        state_nxt      = rxs ? IDLE : DATA;
                    end else begin
                        sample_cnt_nxt = sample_cnt + 4'd1;
                    end
                end
                DATA: begin
                    if (sample_cnt == 4'd15) begin
                        shift_nxt[bit_idx] = rxs;
                        sample_cnt_nxt     = '0;
                        if (bit_idx == 3'd7) begin
                            state_nxt = STOP;
                        end else begin
                            bit_idx_nxt = bit_idx + 3'd1;
                        end
                    end else begin
                        sample_cnt_nxt = sample_cnt + 4'd1;
                    end
                end
                STOP: begin
                    if (sample_cnt == 4'd15) begin
                        push           = rxs;
                        stop_bad       = ~rxs;
                        sample_cnt_nxt = '0;
                        state_nxt      = IDLE;
                    end else begin
                        sample_cnt_nxt = sample_cnt + 4'd1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign full     = (fifo_count == FIFO_FULL);
    assign rx_valid = (fifo_count != 3'd0);
    assign pop      = rx_valid && rx_ready;
    // A same-cycle pop frees the slot, so a full FIFO can still take the byte.
    assign push_ok  = push && (!full || pop);
    assign drop     = push && full && !pop;
    assign rx_data  = mem[rd_ptr];

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                mem[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= shift_reg;
                wr_ptr      <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + 3'd1;
                2'b01:   fifo_count <= fifo_count - 3'd1;
                default: fifo_count <= fifo_count;
            endcase
            frame_err <= stop_bad;
            overrun   <= drop;
        end
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl at OVS_DIV=4 (64 clk_50 cycles per bit).
module tb_uart_rx_ctrl;
    logic       clk_50   = 1'b0;
    logic       rst_n    = 1'b0;
    logic       uart_rx  = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic [2:0] fifo_count;

    int         n_checks = 0;
    int         n_errors = 0;
    int         fe_cnt   = 0;
    int         ov_cnt   = 0;
    int         fe0, ov0;
    logic       fe_prev  = 1'b0;
    logic       ov_prev  = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_byte;
    logic [1:0] m_cnt;

    always #5 clk_50 = ~clk_50;

    uart_rx_ctrl #(.OVS_DIV(4), .FIFO_DEPTH(4)) dut (
        .clk_50     (clk_50),
        .rst_n      (rst_n),
        .uart_rx    (uart_rx),
        .rx_ready   (rx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .fifo_count (fifo_count)
    );

    // Reference oversample phase: free-running 0..3, tick on the edge that follows 3.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) m_cnt <= '0;
        else        m_cnt <= m_cnt + 2'd1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk_50) begin
        if (rst_n) begin
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_spurious", 32'(rx_data), 32'h100);
                end else begin
                    exp_byte = exp_q.pop_front();
                    check("sb_data", 32'(rx_data), 32'(exp_byte));
                end
            end
            if (frame_err) begin
                fe_cnt++;
                check("fe_width", 32'(fe_prev), 0);
            end
            if (overrun) begin
                ov_cnt++;
                check("ov_width", 32'(ov_prev), 0);
            end
            if (frame_err || overrun) check("flag_excl", 32'(frame_err && overrun), 0);
        end
        fe_prev = frame_err;
        ov_prev = overrun;
    end

    task automatic align_tick();
        do begin
            @(posedge clk_50); #1;
        end while (m_cnt != 2'd0);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_valid"}, 32'(rx_valid), 0);
        check({tag, "_count"}, 32'(fifo_count), 0);
        check({tag, "_data"}, 32'(rx_data), 0);
        check({tag, "_fe"}, 32'(frame_err), 0);
        check({tag, "_ov"}, 32'(overrun), 0);
    endtask

    // Cycle n is the interval after edge n; the stop bit is sampled on edge 612.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int ready_at,
                              input bit lat_chk, input int abort_at);
        align_tick();
        for (int n = 0; n < 640; n++) begin
            if (n == abort_at) begin
                #2;
                rst_n = 1'b0;
                #1;
                reset_checks("rst_mid");
                rx_ready = 1'b0;
                uart_rx  = 1'b1;
                exp_q.delete();
                repeat (3) @(posedge clk_50);
                #1;
                rst_n = 1'b1;
                return;
            end
            uart_rx = (n < 64) ? 1'b0 : (n < 576) ? d[(n - 64) / 64] : stop;
            if (n == ready_at)          rx_ready = 1'b1;
            else if (n == ready_at + 1) rx_ready = 1'b0;
            if (lat_chk && n == 611) check("lat_before", 32'(rx_valid), 0);
            if (lat_chk && n == 612) check("lat_after", 32'(rx_valid), 1);
            @(posedge clk_50); #1;
        end
        uart_rx  = 1'b1;
        rx_ready = 1'b0;
        repeat (100) @(posedge clk_50);
        #1;
    endtask

    task automatic drain(input string tag);
        rx_ready = 1'b1;
        for (int i = 0; i < 20 && rx_valid; i++) begin
            @(posedge clk_50); #1;
        end
        rx_ready = 1'b0;
        check({tag, "_count"}, 32'(fifo_count), 0);
        check({tag, "_sb_left"}, 32'(exp_q.size()), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk_50);
        #1;
        reset_checks("reset");
        rst_n = 1'b1;

        // Single byte, consumer stalled
        fe0 = fe_cnt; ov0 = ov_cnt;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, -10, 1'b1, -1);
        check("a5_valid", 32'(rx_valid), 1);
        check("a5_data", 32'(rx_data), 32'hA5);
        check("a5_count", 32'(fifo_count), 1);
        check("a5_flags", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 0);
        drain("a5_drain");

        // Short low glitch on an idle line
        fe0 = fe_cnt; ov0 = ov_cnt;
        align_tick();
        uart_rx = 1'b0;
        repeat (20) @(posedge clk_50);
        #1;
        uart_rx = 1'b1;
        repeat (100) @(posedge clk_50);
        #1;
        check("glitch_count", 32'(fifo_count), 0);
        check("glitch_flags", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 0);

        // Stop bit low
        fe0 = fe_cnt; ov0 = ov_cnt;
        send_frame(8'h3C, 1'b0, -10, 1'b0, -1);
        check("fe_pulses", 32'(fe_cnt - fe0), 1);
        check("fe_ov", 32'(ov_cnt - ov0), 0);
        check("fe_count", 32'(fifo_count), 0);

        // Five bytes into a four-deep FIFO
        fe0 = fe_cnt; ov0 = ov_cnt;
        for (int b = 1; b <= 5; b++) begin
            if (b <= 4) exp_q.push_back(8'(b));
            send_frame(8'(b), 1'b1, -10, 1'b0, -1);
        end
        check("ovr_count", 32'(fifo_count), 4);
        check("ovr_pulses", 32'(ov_cnt - ov0), 1);
        check("ovr_fe", 32'(fe_cnt - fe0), 0);
        drain("ovr_drain");

        // Full FIFO, pop coincides with the stop-bit sample
        ov0 = ov_cnt;
        exp_q.push_back(8'h11); send_frame(8'h11, 1'b1, -10, 1'b0, -1);
        exp_q.push_back(8'h22); send_frame(8'h22, 1'b1, -10, 1'b0, -1);
        exp_q.push_back(8'h33); send_frame(8'h33, 1'b1, -10, 1'b0, -1);
        exp_q.push_back(8'h44); send_frame(8'h44, 1'b1, -10, 1'b0, -1);
        check("same_full", 32'(fifo_count), 4);
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, 611, 1'b0, -1);
        check("same_count", 32'(fifo_count), 4);
        check("same_ov", 32'(ov_cnt - ov0), 0);
        check("same_sb_len", 32'(exp_q.size()), 4);
        drain("same_drain");

        // Reset during bit 4 with two bytes queued
        exp_q.push_back(8'h66); send_frame(8'h66, 1'b1, -10, 1'b0, -1);
        exp_q.push_back(8'h77); send_frame(8'h77, 1'b1, -10, 1'b0, -1);
        check("pre_rst_count", 32'(fifo_count), 2);
        send_frame(8'h99, 1'b1, -10, 1'b0, 64 + 4 * 64 + 20);
        @(posedge clk_50); #1;
        reset_checks("post_rst");
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1, -10, 1'b0, -1);
        check("7e_count", 32'(fifo_count), 1);
        check("7e_data", 32'(rx_data), 32'h7E);
        drain("7e_drain");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
